// File: rtl/mileage_display_pkg.sv
// Shared definitions for the mileage display and future sibling displays.
// Holds the clamp limit, digit count, seven-segment patterns and converter state type.
package mileage_display_pkg;

  localparam logic [26:0] MAX_MILEAGE = 27'd9_999_999;
  localparam int unsigned BCD_DIGITS  = 7;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } conv_state_e;

  // Non-decimal nibbles render blank
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 27-bit binary to 7-digit BCD converter (shift-add-3), one bit per clock.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start_i   - load bin_i and begin a conversion (honoured only when idle)
//   bin_i     - binary value to convert
//   busy_o    - high while converting and during the done cycle
//   done_o    - one-cycle pulse; bcd_o holds the final result in this cycle
//   bcd_o     - 28-bit BCD result
module bin2bcd_seq
  import mileage_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [26:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [27:0] bcd_o
);

  conv_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [26:0] bin_q, bin_d;
  logic [27:0] bcd_q, bcd_d;
  logic [27:0] bcd_adj;
  logic        unused_bcd_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Inputs are clamped below 10^7, so the top BCD bit never carries into the shift
  assign unused_bcd_msb = bcd_adj[27];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        {bcd_d, bin_d} = {bcd_adj[26:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd26) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/mileage_display.sv
// Mileage display: detects odometer changes, converts to BCD and scans an
// eight-digit seven-segment display with leading-zero blanking.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   power_now_i  - display dark when low (scan and conversion continue)
//   record_i     - binary mileage, clamped to 9_999_999
//   seg_en_o     - one-hot digit enable, bit 0 = rightmost digit (registered)
//   seg_out_o    - segments {dp,g,f,e,d,c,b,a} (registered)
//   busy_o       - conversion in progress
module mileage_display
  import mileage_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_now_i,
  input  logic [26:0] record_i,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_out_o,
  output logic        busy_o
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  logic [26:0]   last_val_q, last_val_d;
  logic [27:0]   disp_bcd_q, disp_bcd_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_en_q, seg_en_d;
  logic [7:0]    seg_out_q, seg_out_d;

  logic [26:0] record_clamp;
  logic        start;
  logic        conv_busy;
  logic        conv_done;
  logic [27:0] conv_bcd;
  logic [27:0] digit_sel;
  logic        blank;

  // Compare the clamped value so an out-of-range input does not retrigger forever
  assign record_clamp = (record_i > MAX_MILEAGE) ? MAX_MILEAGE : record_i;
  assign start        = !conv_busy && (record_clamp != last_val_q);

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (record_clamp),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_q <= '0;
      disp_bcd_q <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_en_q   <= '0;
      seg_out_q  <= '0;
    end else begin
      last_val_q <= last_val_d;
      disp_bcd_q <= disp_bcd_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_en_q   <= seg_en_d;
      seg_out_q  <= seg_out_d;
    end
  end

  always_comb begin
    last_val_d = start ? record_clamp : last_val_q;
    disp_bcd_d = conv_done ? conv_bcd : disp_bcd_q;

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end

    // Digit i and everything above it; zero means this digit is a leading zero
    digit_sel = disp_bcd_q >> {idx_q, 2'b00};
    blank     = (idx_q == 3'd7) || ((idx_q != 3'd0) && (digit_sel == '0));

    seg_en_d  = '0;
    seg_out_d = SEG_BLANK;
    if (power_now_i) begin
      seg_en_d = 8'b1 << idx_q;
      if (!blank) begin
        seg_out_d = seg_decode(digit_sel[3:0]);
      end
    end
  end

  assign seg_en_o  = seg_en_q;
  assign seg_out_o = seg_out_q;
  assign busy_o    = conv_busy;

endmodule

// File: tb/tb_mileage_display.sv
module tb_mileage_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        power_now = 1'b1;
  logic [26:0] record = '0;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [27:0] exp_q[$];

  always #5 clk = ~clk;

  mileage_display #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .power_now_i (power_now),
    .record_i    (record),
    .seg_en_o    (seg_en),
    .seg_out_o   (seg_out),
    .busy_o      (busy)
  );

  // Clock edges since the last reset edge; drives the scan-position model
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int clampv(input int v);
    return (v > 9999999) ? 9999999 : v;
  endfunction

  function automatic logic [27:0] to_bcd(input int v);
    logic [27:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 7; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int ndig(input int v);
    int n;
    int x;
    n = 1;
    x = v;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction

  // Enable seen after edge c reflects the index held before that edge (slot = 4 clk)
  function automatic logic [7:0] exp_en(input int c);
    if (c < 1) return 8'h00;
    return 8'(1 << (((c - 1) / 4) % 8));
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    record = 27'(v);
    exp_q.push_back(to_bcd(clampv(v)));
  endtask

  task automatic wait_conv(output int len);
    int guard;
    logic [27:0] e;
    guard = 0;
    len = 0;
    while (!busy && guard < 5) begin
      tick();
      guard++;
    end
    while (busy && len < 60) begin
      tick();
      len++;
    end
    checks++;
    if (busy || len == 0) begin
      errors++;
      $display("FAIL conv_timeout: busy=%0b cycles=%0d, required one finished conversion", busy, len);
    end
    checks++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
    if (dut.disp_bcd_q !== e) begin
      errors++;
      $display("FAIL disp_bcd: got %h required %h", dut.disp_bcd_q, e);
    end
  endtask

  task automatic convert(input int v);
    int len;
    drive(v);
    wait_conv(len);
    checks++;
    if (len != 28) begin
      errors++;
      $display("FAIL busy_len(%0d): got %0d required 28", v, len);
    end
  endtask

  task automatic check_display(input int v_in);
    logic [7:0] got[8];
    bit seen[8];
    int en_err;
    int v;
    int p;
    logic [7:0] e;
    v = clampv(v_in);
    en_err = 0;
    for (int k = 0; k < 8; k++) begin
      got[k] = 8'hxx;
      seen[k] = 1'b0;
    end
    for (int t = 0; t < 40; t++) begin
      if (seg_en !== exp_en(cyc)) en_err++;
      for (int k = 0; k < 8; k++) begin
        if (seg_en === 8'(1 << k)) begin
          got[k] = seg_out;
          seen[k] = 1'b1;
        end
      end
      tick();
    end
    checks++;
    if (en_err != 0) begin
      errors++;
      $display("FAIL scan_enable(%0d): %0d bad cycles, required 0", v, en_err);
    end
    p = 1;
    for (int k = 0; k < 8; k++) begin
      e = (k < ndig(v) && k < 7) ? pat((v / p) % 10) : 8'h00;
      checks++;
      if (!seen[k] || got[k] !== e) begin
        errors++;
        $display("FAIL digit%0d(%0d): got %h required %h", k, v, got[k], e);
      end
      if (k < 7) p = p * 10;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    record = '0;
    power_now = 1'b1;
    tick(3);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (seg_en !== 8'h00) begin errors++; $display("FAIL rst_seg_en: got %h required 00", seg_en); end
    if (seg_out !== 8'h00) begin errors++; $display("FAIL rst_seg_out: got %h required 00", seg_out); end
    if (dut.disp_bcd_q !== 28'h0) begin
      errors++;
      $display("FAIL rst_disp: got %h required 0", dut.disp_bcd_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    tick(29);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
    if (dut.disp_bcd_q !== 28'h0) begin
      errors++;
      $display("FAIL zero_disp: got %h required 0", dut.disp_bcd_q);
    end
    check_display(0);
  endtask

  task automatic test_main();
    convert(1234567);
    check_display(1234567);
  endtask

  task automatic test_clamp();
    convert(120000000);
    check_display(120000000);
  endtask

  task automatic test_back_to_back();
    int len;
    drive(41);
    tick(6);
    drive(42);
    wait_conv(len);
    wait_conv(len);
    checks++;
    if (len != 28) begin errors++; $display("FAIL b2b_busy_len: got %0d required 28", len); end
    check_display(42);
  endtask

  task automatic test_reset_midconv();
    int len;
    drive(500);
    tick(11);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midconv_busy: got %b required 1", busy); end
    rst = 1'b1;
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (dut.disp_bcd_q !== 28'h0) begin
      errors++;
      $display("FAIL midrst_disp: got %h required 0", dut.disp_bcd_q);
    end
    rst = 1'b0;
    wait_conv(len);
    checks++;
    if (len != 28) begin errors++; $display("FAIL restart_busy_len: got %0d required 28", len); end
    check_display(500);
  endtask

  task automatic test_power();
    int dark_err;
    int guard;
    int width;
    logic [7:0] cur;
    convert(999);
    check_display(999);
    power_now = 1'b0;
    dark_err = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (seg_en !== 8'h00 || seg_out !== 8'h00) dark_err++;
    end
    checks++;
    if (dark_err != 0) begin
      errors++;
      $display("FAIL power_dark: %0d lit cycles, required 0", dark_err);
    end
    power_now = 1'b1;
    tick();
    checks++;
    if (seg_en !== exp_en(cyc)) begin
      errors++;
      $display("FAIL power_index: got %h required %h", seg_en, exp_en(cyc));
    end
    cur = seg_en;
    guard = 0;
    while (seg_en === cur && guard < 8) begin
      tick();
      guard++;
    end
    cur = seg_en;
    width = 0;
    while (seg_en === cur && width < 10) begin
      tick();
      width++;
    end
    checks++;
    if (width != 4) begin errors++; $display("FAIL slot_width: got %0d required 4", width); end
    check_display(999);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_main();
    test_clamp();
    test_back_to_back();
    test_reset_midconv();
    test_power();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
